search_requester: RTL and testbench

- Requestor-side client for the sorted-table binary search engine.
- Buffers search keys from an upstream producer in a small FIFO and issues them one at a time on the engine's request_key / request_key_valid interface.
- Waits for the matching response_valid or no_match_found, then presents each result with its original key on a valid/ready result port.
- A watchdog flags any search whose response never arrives.

---
 rtl/search_requester.sv | 140 ++++++++++++++
 tb/tb_search_requester.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/search_requester.sv
// Queues search keys, issues them one at a time to the binary-search engine,
// and returns each result with its key on a valid/ready port (watchdog-guarded).
module search_requester #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [DATA_WIDTH-1:0]    key_in,
  input  logic                     key_in_valid,
  output logic                     key_in_ready,
  output logic [DATA_WIDTH-1:0]    request_key,
  output logic                     request_key_valid,
  input  logic [$clog2(DEPTH)-1:0] response_index,
  input  logic                     response_valid,
  input  logic                     no_match_found,
  output logic [DATA_WIDTH-1:0]    result_key,
  output logic [$clog2(DEPTH)-1:0] result_index,
  output logic                     result_found,
  output logic                     result_timeout,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     busy
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic [WW-1:0]         wd_q;
  logic [DATA_WIDTH-1:0] req_key_q, res_key_q;
  logic                  req_vld_q, res_found_q, res_timeout_q, res_vld_q;
  logic [IW-1:0]         res_idx_q;

  assign key_in_ready = (count_q != FULL);
  assign push         = key_in_valid && key_in_ready;
  assign pop          = (state_q == IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_q] <= key_in;
  end

  // Engine pulses are only honoured in WAIT, so stray or post-reset pulses are dropped.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      key_q         <= '0;
      wd_q          <= '0;
      req_key_q     <= '0;
      req_vld_q     <= 1'b0;
      res_key_q     <= '0;
      res_idx_q     <= '0;
      res_found_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_vld_q     <= 1'b0;
    end else begin
      req_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            key_q   <= mem[rd_ptr_q];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          req_key_q <= key_q;
          req_vld_q <= 1'b1;
          wd_q      <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (wd_q != WD_MAX) wd_q <= wd_q + WW'(1);
          if (response_valid || no_match_found || (wd_q == WD_LAST)) begin
            res_key_q     <= key_q;
            res_vld_q     <= 1'b1;
            res_found_q   <= response_valid;
            res_idx_q     <= response_valid ? response_index : '0;
            res_timeout_q <= !response_valid && !no_match_found;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (result_ready) begin
            res_vld_q     <= 1'b0;
            res_found_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign request_key       = req_key_q;
  assign request_key_valid = req_vld_q;
  assign result_key        = res_key_q;
  assign result_index      = res_idx_q;
  assign result_found      = res_found_q;
  assign result_timeout    = res_timeout_q;
  assign result_valid      = res_vld_q;
  assign busy              = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_search_requester.sv
// Directed bench for search_requester with a small latency-programmable engine model.
module tb_search_requester;
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [15:0] key_in;
  logic        key_in_valid;
  logic        key_in_ready;
  logic [15:0] request_key;
  logic        request_key_valid;
  logic [3:0]  response_index;
  logic        response_valid;
  logic        no_match_found;
  logic [15:0] result_key;
  logic [3:0]  result_index;
  logic        result_found;
  logic        result_timeout;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic       eng_rv = 1'b0, eng_nm = 1'b0;
  logic [3:0] eng_idx_o = 4'd0;
  logic       tb_rv = 1'b0, tb_nm = 1'b0;
  logic [3:0] tb_idx = 4'd0;
  int         eng_mode = 0;
  int         eng_lat = 1;
  logic [3:0] eng_idx = 4'd0;
  int         eng_cnt = 0;
  int         req_cnt = 0;

  assign response_valid = eng_rv | tb_rv;
  assign no_match_found = eng_nm | tb_nm;
  assign response_index = (tb_rv | tb_nm) ? tb_idx : eng_idx_o;

  search_requester #(.DATA_WIDTH(16), .DEPTH(16), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .key_in(key_in), .key_in_valid(key_in_valid), .key_in_ready(key_in_ready),
    .request_key(request_key), .request_key_valid(request_key_valid),
    .response_index(response_index), .response_valid(response_valid),
    .no_match_found(no_match_found),
    .result_key(result_key), .result_index(result_index), .result_found(result_found),
    .result_timeout(result_timeout), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Engine model: mode 1 = match with eng_idx, 2 = no match, 0 = silent; pulse eng_lat cycles after the request.
  always @(negedge Clk) begin
    eng_rv = 1'b0;
    eng_nm = 1'b0;
    eng_idx_o = 4'd0;
    if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) begin
        if (eng_mode == 1) begin
          eng_rv = 1'b1;
          eng_idx_o = eng_idx;
        end else if (eng_mode == 2) begin
          eng_nm = 1'b1;
        end
      end
    end
    if (request_key_valid === 1'b1 && eng_mode != 0) eng_cnt = eng_lat;
  end

  always @(posedge Clk) begin
    if (request_key_valid === 1'b1) req_cnt = req_cnt + 1;
  end

  task automatic tick;
    @(negedge Clk);
  endtask

  task automatic wait_req(input int limit, output int n);
    n = 0;
    while (request_key_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    if (request_key_valid !== 1'b1) n = -1;
  endtask

  task automatic wait_res(input int limit, output int n);
    n = 0;
    while (result_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    if (result_valid !== 1'b1) n = -1;
  endtask

  task automatic push_one(input logic [15:0] k);
    key_in = k;
    key_in_valid = 1'b1;
    tick();
    key_in_valid = 1'b0;
  endtask

  task automatic release_result;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    tick();
    n_checks++; if (key_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_in_ready: got %b want 1", key_in_ready); end
    n_checks++; if (request_key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", request_key_valid); end
    n_checks++; if (request_key !== 16'h0) begin n_fail++; $display("FAIL reset_req_key: got %h want 0", request_key); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
    n_checks++; if (result_found !== 1'b0) begin n_fail++; $display("FAIL reset_result_found: got %b want 0", result_found); end
    n_checks++; if (result_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_result_timeout: got %b want 0", result_timeout); end
    n_checks++; if (result_key !== 16'h0) begin n_fail++; $display("FAIL reset_result_key: got %h want 0", result_key); end
    n_checks++; if (result_index !== 4'h0) begin n_fail++; $display("FAIL reset_result_index: got %h want 0", result_index); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_found;
    int n, r0;
    eng_mode = 1; eng_lat = 9; eng_idx = 4'd5;
    r0 = req_cnt;
    push_one(16'h0030);
    wait_req(20, n);
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL found_issue_latency: got %0d want 2", n); end
    n_checks++; if (request_key !== 16'h0030) begin n_fail++; $display("FAIL found_req_key: got %h want 0030", request_key); end
    wait_res(100, n);
    n_checks++; if (n !== 10) begin n_fail++; $display("FAIL found_result_latency: got %0d want 10", n); end
    n_checks++; if (result_key !== 16'h0030) begin n_fail++; $display("FAIL found_key: got %h want 0030", result_key); end
    n_checks++; if (result_index !== 4'd5) begin n_fail++; $display("FAIL found_index: got %0d want 5", result_index); end
    n_checks++; if (result_found !== 1'b1) begin n_fail++; $display("FAIL found_flag: got %b want 1", result_found); end
    n_checks++; if (result_timeout !== 1'b0) begin n_fail++; $display("FAIL found_timeout: got %b want 0", result_timeout); end
    n_checks++; if (req_cnt - r0 !== 1) begin n_fail++; $display("FAIL found_req_pulses: got %0d want 1", req_cnt - r0); end
    release_result();
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL found_valid_clear: got %b want 0", result_valid); end
    n_checks++; if (result_found !== 1'b0) begin n_fail++; $display("FAIL found_flag_clear: got %b want 0", result_found); end
    n_checks++; if (request_key !== 16'h0030) begin n_fail++; $display("FAIL found_req_key_hold: got %h want 0030", request_key); end
  endtask

  task automatic test_no_match;
    int n;
    eng_mode = 2; eng_lat = 3;
    push_one(16'h0031);
    wait_req(20, n);
    wait_res(100, n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL nomatch_latency: got %0d want 4", n); end
    n_checks++; if (result_key !== 16'h0031) begin n_fail++; $display("FAIL nomatch_key: got %h want 0031", result_key); end
    n_checks++; if (result_found !== 1'b0) begin n_fail++; $display("FAIL nomatch_found: got %b want 0", result_found); end
    n_checks++; if (result_index !== 4'd0) begin n_fail++; $display("FAIL nomatch_index: got %0d want 0", result_index); end
    n_checks++; if (result_timeout !== 1'b0) begin n_fail++; $display("FAIL nomatch_timeout: got %b want 0", result_timeout); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nomatch_busy_hold: got %b want 1", busy); end
    release_result();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nomatch_busy_drop: got %b want 0", busy); end
  endtask

  task automatic test_fifo_full;
    int got, r0;
    logic do_push;
    logic [15:0] got_keys [6];
    eng_mode = 1; eng_lat = 2; eng_idx = 4'd5;
    result_ready = 1'b0;
    r0 = req_cnt;
    for (int i = 1; i <= 5; i++) begin
      key_in = 16'(i);
      key_in_valid = 1'b1;
      n_checks++; if (key_in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_key%0d: got %b want 1", i, key_in_ready); end
      tick();
    end
    key_in = 16'h0006;
    n_checks++; if (key_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_drop: got %b want 0", key_in_ready); end
    repeat (6) tick();
    n_checks++; if (key_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_held: got %b want 0", key_in_ready); end
    n_checks++; if (result_valid !== 1'b1 || result_key !== 16'h0001) begin n_fail++; $display("FAIL full_first_held: got valid %b key %h want 1/0001", result_valid, result_key); end
    result_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      do_push = key_in_valid && key_in_ready;
      if (result_valid === 1'b1) begin
        got_keys[got] = result_key;
        got++;
      end
      tick();
      if (do_push) key_in_valid = 1'b0;
    end
    result_ready = 1'b0;
    n_checks++; if (got !== 6) begin n_fail++; $display("FAIL full_result_count: got %0d want 6", got); end
    for (int i = 0; i < got; i++) begin
      n_checks++; if (got_keys[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL full_order_%0d: got %h want %h", i, got_keys[i], 16'(i + 1)); end
    end
    repeat (3) tick();
    n_checks++; if (req_cnt - r0 !== 6) begin n_fail++; $display("FAIL full_req_pulses: got %0d want 6", req_cnt - r0); end
    n_checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got busy %b valid %b want 0/0", busy, result_valid); end
  endtask

  task automatic test_timeout;
    int n;
    eng_mode = 0;
    push_one(16'h0077);
    wait_req(20, n);
    n_checks++; if (n < 0) begin n_fail++; $display("FAIL timeout_no_issue: got none want pulse"); end
    wait_res(100, n);
    n_checks++; if (n !== 64) begin n_fail++; $display("FAIL timeout_latency: got %0d want 64", n); end
    n_checks++; if (result_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b want 1", result_timeout); end
    n_checks++; if (result_found !== 1'b0 || result_index !== 4'd0) begin n_fail++; $display("FAIL timeout_fields: got found %b idx %0d want 0/0", result_found, result_index); end
    n_checks++; if (result_key !== 16'h0077) begin n_fail++; $display("FAIL timeout_key: got %h want 0077", result_key); end
    release_result();
    n_checks++; if (result_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b want 0", result_timeout); end
  endtask

  task automatic test_stray;
    int n;
    eng_mode = 1; eng_lat = 2; eng_idx = 4'd5;
    push_one(16'h0040);
    wait_req(20, n);
    wait_res(100, n);
    tb_rv = 1'b1; tb_idx = 4'd9;
    tick();
    tb_rv = 1'b0; tb_nm = 1'b1;
    tick();
    tb_nm = 1'b0;
    n_checks++; if (result_valid !== 1'b1 || result_found !== 1'b1) begin n_fail++; $display("FAIL stray_hold_flags: got valid %b found %b want 1/1", result_valid, result_found); end
    n_checks++; if (result_index !== 4'd5) begin n_fail++; $display("FAIL stray_hold_index: got %0d want 5", result_index); end
    n_checks++; if (result_key !== 16'h0040) begin n_fail++; $display("FAIL stray_hold_key: got %h want 0040", result_key); end
    release_result();
    eng_mode = 0;
    push_one(16'h0041);
    wait_req(20, n);
    tick();
    tb_rv = 1'b1; tb_nm = 1'b1; tb_idx = 4'd11;
    tick();
    tb_rv = 1'b0; tb_nm = 1'b0;
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL both_valid: got %b want 1", result_valid); end
    n_checks++; if (result_found !== 1'b1 || result_index !== 4'd11) begin n_fail++; $display("FAIL both_found: got found %b idx %0d want 1/11", result_found, result_index); end
    n_checks++; if (result_key !== 16'h0041 || result_timeout !== 1'b0) begin n_fail++; $display("FAIL both_key: got key %h to %b want 0041/0", result_key, result_timeout); end
    release_result();
  endtask

  task automatic test_reset_mid;
    int n, r0;
    logic seen;
    eng_mode = 0;
    key_in = 16'h0050; key_in_valid = 1'b1; tick();
    key_in = 16'h0051; tick();
    key_in = 16'h0052; tick();
    key_in_valid = 1'b0;
    wait_req(20, n);
    tick(); tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    Rst_n = 1'b0;
    #1;
    n_checks++; if (key_in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_busy: got %b/%b want 1/0", key_in_ready, busy); end
    n_checks++; if (request_key_valid !== 1'b0 || request_key !== 16'h0) begin n_fail++; $display("FAIL rstmid_req: got %b/%h want 0/0", request_key_valid, request_key); end
    n_checks++; if (result_valid !== 1'b0 || result_key !== 16'h0) begin n_fail++; $display("FAIL rstmid_result: got %b/%h want 0/0", result_valid, result_key); end
    tick(); tick();
    Rst_n = 1'b1;
    r0 = req_cnt;
    tick();
    tb_rv = 1'b1; tb_idx = 4'd3;
    tick();
    tb_rv = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      if (result_valid !== 1'b0 || request_key_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_pulse: got activity want none"); end
    n_checks++; if (req_cnt - r0 !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got pulses %0d busy %b want 0/0", req_cnt - r0, busy); end
  endtask

  initial begin
    Rst_n = 1'b0;
    key_in = 16'h0;
    key_in_valid = 1'b0;
    result_ready = 1'b0;
    test_reset();
    test_basic_found();
    test_no_match();
    test_fifo_full();
    test_timeout();
    test_stray();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
